// File: rtl/clock_pkg.sv
// Shared time-field widths and terminal values for the digital clock.
// Used by the time counter, the adjust block and the display decoder.
package clock_pkg;

    localparam int TIME_W    = 6;
    localparam int SEC_LAST  = 59;
    localparam int MIN_LAST  = 59;
    localparam int HOUR_LAST = 23;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-(LAST+1) counter with priority load and combinational wrap flag.
// Out-of-range load values are clamped to zero.
module mod_n_counter
    import clock_pkg::*;
#(
    parameter int WIDTH = TIME_W,
    parameter int LAST  = SEC_LAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    // Terminal compare happens before incrementing, so LAST+1 never appears
    assign wrap = en && (value == LAST_V);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value <= '0;
        end else if (load) begin
            value <= (load_val > LAST_V) ? '0 : load_val;
        end else if (en) begin
            value <= wrap ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Timekeeping core: 1 Hz prescaler plus 24 h seconds/minutes/hours.
// Accepts adjusted minute/hour values from the time-adjust block.
module time_counter
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              load_i,
    input  logic [TIME_W-1:0] minute_i,
    input  logic [TIME_W-1:0] hour_i,
    output logic [TIME_W-1:0] second_o,
    output logic [TIME_W-1:0] minute_o,
    output logic [TIME_W-1:0] hour_o,
    output logic              sec_tick_o,
    output logic              min_carry_o,
    output logic              day_carry_o
);

    localparam int PRESC_W = $clog2(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               sec_wrap;
    logic               min_wrap;
    logic               hour_wrap;

    // A load on the same edge swallows the tick
    assign tick = run_i && !load_i && (presc == PRESC_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc <= '0;
        end else if (load_i) begin
            presc <= '0;
        end else if (run_i) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    mod_n_counter #(.WIDTH(TIME_W), .LAST(SEC_LAST)) u_sec (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en       (tick),
        .load     (load_i),
        .load_val ('0),
        .value    (second_o),
        .wrap     (sec_wrap)
    );

    mod_n_counter #(.WIDTH(TIME_W), .LAST(MIN_LAST)) u_min (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en       (sec_wrap),
        .load     (load_i),
        .load_val (minute_i),
        .value    (minute_o),
        .wrap     (min_wrap)
    );

    mod_n_counter #(.WIDTH(TIME_W), .LAST(HOUR_LAST)) u_hour (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en       (min_wrap),
        .load     (load_i),
        .load_val (hour_i),
        .value    (hour_o),
        .wrap     (hour_wrap)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sec_tick_o  <= 1'b0;
            min_carry_o <= 1'b0;
            day_carry_o <= 1'b0;
        end else begin
            sec_tick_o  <= tick;
            min_carry_o <= sec_wrap;
            day_carry_o <= hour_wrap;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter against a seconds-of-day model.
module tb_time_counter;

    localparam int T = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       run_i = 1'b0;
    logic       load_i = 1'b0;
    logic [5:0] minute_i = '0;
    logic [5:0] hour_i = '0;
    logic [5:0] second_o;
    logic [5:0] minute_o;
    logic [5:0] hour_o;
    logic       sec_tick_o;
    logic       min_carry_o;
    logic       day_carry_o;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: prescaler count and seconds since midnight
    int m_presc = 0;
    int m_tod = 0;
    bit m_tick = 0;
    bit m_minc = 0;
    bit m_dayc = 0;

    time_counter #(.TICKS_PER_SEC(T)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run_i),
        .load_i      (load_i),
        .minute_i    (minute_i),
        .hour_i      (hour_i),
        .second_o    (second_o),
        .minute_o    (minute_o),
        .hour_o      (hour_o),
        .sec_tick_o  (sec_tick_o),
        .min_carry_o (min_carry_o),
        .day_carry_o (day_carry_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [20:0] dut_vec();
        return {second_o, minute_o, hour_o, sec_tick_o, min_carry_o, day_carry_o};
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [5:0] s, m, h;
        s = 6'(m_tod % 60);
        m = 6'((m_tod / 60) % 60);
        h = 6'(m_tod / 3600);
        return {s, m, h, m_tick, m_minc, m_dayc};
    endfunction

    task automatic model_reset();
        m_presc = 0;
        m_tod = 0;
        m_tick = 0;
        m_minc = 0;
        m_dayc = 0;
    endtask

    task automatic model_edge();
        int mm, hh;
        if (!rst_ni) return;
        m_tick = 0;
        m_minc = 0;
        m_dayc = 0;
        if (load_i) begin
            mm = (int'(minute_i) > 59) ? 0 : int'(minute_i);
            hh = (int'(hour_i) > 23) ? 0 : int'(hour_i);
            m_tod = hh * 3600 + mm * 60;
            m_presc = 0;
        end else if (run_i) begin
            if (m_presc == T - 1) begin
                m_presc = 0;
                m_tod = (m_tod + 1) % 86400;
                m_tick = 1;
                m_minc = (m_tod % 60 == 0);
                m_dayc = (m_tod == 0);
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic do_load(input int mn, input int hr);
        load_i = 1'b1;
        minute_i = 6'(mn);
        hour_i = 6'(hr);
        step();
        load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        run_i = 1'b0;
        #3;
        model_reset();
        n_checks++;
        if (dut_vec() !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 21'd0);
        end
        step();
        step();
        rst_ni = 1'b1;
        run_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL run_cycle%0d: got %h want %h", k, dut_vec(), exp_vec());
            end
            n_checks++;
            if (sec_tick_o !== (k % 4 == 0)) begin
                n_fail++;
                $display("FAIL tick_cycle%0d: got %b want %b", k, sec_tick_o, k % 4 == 0);
            end
        end
        n_checks++;
        if ({second_o, minute_o, hour_o} !== {6'd2, 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL run_8: got %0d:%0d:%0d want 0:0:2", hour_o, minute_o, second_o);
        end
    endtask

    task automatic test_rollover();
        do_load(59, 23);
        n_checks++;
        if ({hour_o, minute_o, second_o} !== {6'd23, 6'd59, 6'd0}) begin
            n_fail++;
            $display("FAIL roll_load: got %0d:%0d:%0d want 23:59:0", hour_o, minute_o, second_o);
        end
        for (int k = 0; k < 236; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL roll_run%0d: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({hour_o, minute_o, second_o} !== {6'd23, 6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL roll_235959: got %0d:%0d:%0d want 23:59:59", hour_o, minute_o, second_o);
        end
        repeat (4) step();
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd0, 6'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL roll_wrap: got %h want %h", dut_vec(), {18'd0, 3'b111});
        end
        step();
        n_checks++;
        if ({sec_tick_o, min_carry_o, day_carry_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL roll_pulse_len: got %b want 000", {sec_tick_o, min_carry_o, day_carry_o});
        end
    endtask

    task automatic test_collision();
        do_load(0, 0);
        repeat (43) step();
        n_checks++;
        if (second_o !== 6'd10 || m_presc != 3) begin
            n_fail++;
            $display("FAIL coll_setup: got sec %0d presc %0d want 10 3", second_o, m_presc);
        end
        do_load(5, 7);
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd5, 6'd7, 3'b000}) begin
            n_fail++;
            $display("FAIL coll_load: got %h want %h", dut_vec(), {6'd0, 6'd5, 6'd7, 3'b000});
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (sec_tick_o !== (k == 4) || second_o !== 6'(k / 4)) begin
                n_fail++;
                $display("FAIL coll_after%0d: got tick %b sec %0d want %b %0d",
                         k, sec_tick_o, second_o, k == 4, k / 4);
            end
        end
    endtask

    task automatic test_out_of_range();
        do_load(60, 30);
        n_checks++;
        if ({hour_o, minute_o, second_o} !== 18'd0) begin
            n_fail++;
            $display("FAIL oor_60_30: got %0d:%0d:%0d want 0:0:0", hour_o, minute_o, second_o);
        end
        do_load(58, 24);
        n_checks++;
        if ({hour_o, minute_o, second_o} !== {6'd0, 6'd58, 6'd0}) begin
            n_fail++;
            $display("FAIL oor_58_24: got %0d:%0d:%0d want 0:58:0", hour_o, minute_o, second_o);
        end
    endtask

    task automatic test_hold();
        do_load(34, 12);
        repeat (226) step();
        run_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== {6'd56, 6'd34, 6'd12, 3'b000}) begin
                n_fail++;
                $display("FAIL hold%0d: got %h want %h", k, dut_vec(), {6'd56, 6'd34, 6'd12, 3'b000});
            end
        end
        run_i = 1'b1;
        step();
        n_checks++;
        if (second_o !== 6'd56 || sec_tick_o !== 1'b0) begin
            n_fail++;
            $display("FAIL resume1: got sec %0d tick %b want 56 0", second_o, sec_tick_o);
        end
        step();
        n_checks++;
        if (second_o !== 6'd57 || sec_tick_o !== 1'b1) begin
            n_fail++;
            $display("FAIL resume2: got sec %0d tick %b want 57 1", second_o, sec_tick_o);
        end
        run_i = 1'b0;
        do_load(1, 2);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (dut_vec() !== {6'd0, 6'd1, 6'd2, 3'b000}) begin
                n_fail++;
                $display("FAIL hold_load%0d: got %h want %h", k, dut_vec(), {6'd0, 6'd1, 6'd2, 3'b000});
            end
            step();
        end
        run_i = 1'b1;
    endtask

    task automatic test_async_reset();
        do_load(6, 5);
        repeat (28) step();
        n_checks++;
        if ({hour_o, minute_o, second_o} !== {6'd5, 6'd6, 6'd7}) begin
            n_fail++;
            $display("FAIL areset_setup: got %0d:%0d:%0d want 5:6:7", hour_o, minute_o, second_o);
        end
        #1;
        rst_ni = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== 21'd0) begin
            n_fail++;
            $display("FAIL areset: got %h want %h", dut_vec(), 21'd0);
        end
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            run_i = ($urandom_range(0, 9) != 0);
            load_i = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1) begin
                minute_i = 6'd59;
                hour_i = 6'd23;
            end else begin
                minute_i = 6'($urandom_range(0, 63));
                hour_i = 6'($urandom_range(0, 63));
            end
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand%0d: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
        load_i = 1'b0;
        run_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_collision();
        test_out_of_range();
        test_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
